// File: rtl/load_store_unit_pkg.sv
// Shared types for the tiny5 load/store unit: access sizes, funct3 encodings
// and the LSU state encoding.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_access_size_t;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_load_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } funct3_store_t;

    typedef enum logic [1:0] {
        LSU_IDLE     = 2'b00,
        LSU_BUS_REQ  = 2'b01,
        LSU_BUS_WAIT = 2'b10,
        LSU_RESP     = 2'b11
    } lsu_state_t;

    // Word-aligned form of a byte address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Datapath request/response and data-memory bus signals of the LSU.
// master = the LSU itself, slave = datapath plus memory environment.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_is_store_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              resp_valid_o;
    logic [31:0]       resp_rdata_o;
    logic              resp_misaligned_o;
    logic              resp_bus_error_o;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_wr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic              mem_resp_valid_i;
    logic [31:0]       mem_rdata_i;

    modport master (
        input  req_valid_i, req_is_store_i, req_size_i, req_unsigned_i,
               req_addr_i, req_wdata_i, mem_req_ready_i, mem_resp_valid_i,
               mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_misaligned_o,
               resp_bus_error_o, mem_req_valid_o, mem_addr_o, mem_wr_o,
               mem_wdata_o, mem_be_o
    );

    modport slave (
        output req_valid_i, req_is_store_i, req_size_i, req_unsigned_i,
               req_addr_i, req_wdata_i, mem_req_ready_i, mem_resp_valid_i,
               mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_misaligned_o,
               resp_bus_error_o, mem_req_valid_o, mem_addr_o, mem_wr_o,
               mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication and byte enables, alignment
// check, and load extraction with zero/sign extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_lanes_o,
    output logic [3:0]  be_o,
    output logic        misaligned_o,
    output logic [31:0] rdata_ext_o
);
    logic [31:0] shifted_s;

    // Bring the addressed lane down to bit 0.
    always_comb begin
        shifted_s = rdata_i >> {offset_i, 3'b000};
    end

    // Per-size lane handling; size 2'b11 is illegal and reported as misaligned.
    always_comb begin
        wdata_lanes_o = 32'h0000_0000;
        be_o          = 4'b0000;
        misaligned_o  = 1'b0;
        rdata_ext_o   = 32'h0000_0000;
        case (size_i)
            MEM_BYTE: begin
                wdata_lanes_o = {4{wdata_i[7:0]}};
                be_o          = 4'b0001 << offset_i;
                rdata_ext_o   = {{24{~unsigned_i & shifted_s[7]}}, shifted_s[7:0]};
            end
            MEM_HALF: begin
                wdata_lanes_o = {2{wdata_i[15:0]}};
                be_o          = 4'b0011 << offset_i;
                misaligned_o  = offset_i[0];
                rdata_ext_o   = {{16{~unsigned_i & shifted_s[15]}}, shifted_s[15:0]};
            end
            MEM_WORD: begin
                wdata_lanes_o = wdata_i;
                be_o          = 4'b1111;
                misaligned_o  = |offset_i;
                rdata_ext_o   = shifted_s;
            end
            default: begin
                misaligned_o  = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// tiny5 memory-access stage: one load/store per transaction over a
// valid/ready data-memory bus, with misalignment and timeout reporting.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_W         = 32
) (
    input  logic clk_i,
    input  logic reset_i,
    load_store_unit_if.master bus
);
    localparam int CNT_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int CNT_MAX    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_misaligned_q, resp_misaligned_d;
    logic              resp_bus_error_q, resp_bus_error_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wr_q, mem_wr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        offset_q, offset_d;
    logic              unsigned_q, unsigned_d;

    logic [1:0]        al_size_s;
    logic [1:0]        al_offset_s;
    logic              al_unsigned_s;
    logic [31:0]       al_wdata_lanes_s;
    logic [3:0]        al_be_s;
    logic              al_misaligned_s;
    logic [31:0]       al_rdata_ext_s;

    // One aligner serves both paths: live request fields in IDLE, registered ones afterwards.
    always_comb begin
        if (state_q == LSU_IDLE) begin
            al_size_s     = bus.req_size_i;
            al_offset_s   = bus.req_addr_i[1:0];
            al_unsigned_s = bus.req_unsigned_i;
        end else begin
            al_size_s     = size_q;
            al_offset_s   = offset_q;
            al_unsigned_s = unsigned_q;
        end
    end

    lsu_align u_align (
        .size_i        (al_size_s),
        .offset_i      (al_offset_s),
        .unsigned_i    (al_unsigned_s),
        .wdata_i       (bus.req_wdata_i),
        .rdata_i       (bus.mem_rdata_i),
        .wdata_lanes_o (al_wdata_lanes_s),
        .be_o          (al_be_s),
        .misaligned_o  (al_misaligned_s),
        .rdata_ext_o   (al_rdata_ext_s)
    );

    // Next-state and next-output logic; response fields are zero unless entering RESP.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        resp_misaligned_d = 1'b0;
        resp_bus_error_d  = 1'b0;
        resp_rdata_d      = 32'h0000_0000;
        mem_addr_d        = mem_addr_q;
        mem_wr_d          = mem_wr_q;
        mem_wdata_d       = mem_wdata_q;
        mem_be_d          = mem_be_q;
        size_d            = size_q;
        offset_d          = offset_q;
        unsigned_d        = unsigned_q;
        case (state_q)
            LSU_IDLE: begin
                if (bus.req_valid_i && req_ready_q) begin
                    mem_addr_d  = {bus.req_addr_i[ADDR_W-1:2], 2'b00};
                    mem_wr_d    = bus.req_is_store_i;
                    mem_wdata_d = al_wdata_lanes_s;
                    mem_be_d    = al_be_s;
                    size_d      = bus.req_size_i;
                    offset_d    = bus.req_addr_i[1:0];
                    unsigned_d  = bus.req_unsigned_i;
                    if (al_misaligned_s) begin
                        state_d           = LSU_RESP;
                        resp_misaligned_d = 1'b1;
                    end else begin
                        state_d           = LSU_BUS_REQ;
                    end
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_BUS_REQ: begin
                if (mem_req_valid_q && bus.mem_req_ready_i) begin
                    state_d = LSU_BUS_WAIT;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = LSU_BUS_REQ;
                end
            end
            LSU_BUS_WAIT: begin
                // A response coinciding with the last timeout cycle still completes normally.
                if (bus.mem_resp_valid_i) begin
                    state_d = LSU_RESP;
                    if (!mem_wr_q) begin
                        resp_rdata_d = al_rdata_ext_s;
                    end else begin
                        resp_rdata_d = 32'h0000_0000;
                    end
                end else if (TIMEOUT_EN && (cnt_q == CNT_W'(CNT_MAX))) begin
                    state_d          = LSU_RESP;
                    resp_bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
        req_ready_d     = (state_d == LSU_IDLE);
        mem_req_valid_d = (state_d == LSU_BUS_REQ);
        resp_valid_d    = (state_d == LSU_RESP);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q           <= LSU_IDLE;
            cnt_q             <= {CNT_W{1'b0}};
            req_ready_q       <= 1'b1;
            resp_valid_q      <= 1'b0;
            resp_misaligned_q <= 1'b0;
            resp_bus_error_q  <= 1'b0;
            resp_rdata_q      <= 32'h0000_0000;
            mem_req_valid_q   <= 1'b0;
            mem_addr_q        <= {ADDR_W{1'b0}};
            mem_wr_q          <= 1'b0;
            mem_wdata_q       <= 32'h0000_0000;
            mem_be_q          <= 4'b0000;
            size_q            <= 2'b00;
            offset_q          <= 2'b00;
            unsigned_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            req_ready_q       <= req_ready_d;
            resp_valid_q      <= resp_valid_d;
            resp_misaligned_q <= resp_misaligned_d;
            resp_bus_error_q  <= resp_bus_error_d;
            resp_rdata_q      <= resp_rdata_d;
            mem_req_valid_q   <= mem_req_valid_d;
            mem_addr_q        <= mem_addr_d;
            mem_wr_q          <= mem_wr_d;
            mem_wdata_q       <= mem_wdata_d;
            mem_be_q          <= mem_be_d;
            size_q            <= size_d;
            offset_q          <= offset_d;
            unsigned_q        <= unsigned_d;
        end
    end

    assign bus.req_ready_o       = req_ready_q;
    assign bus.resp_valid_o      = resp_valid_q;
    assign bus.resp_rdata_o      = resp_rdata_q;
    assign bus.resp_misaligned_o = resp_misaligned_q;
    assign bus.resp_bus_error_o  = resp_bus_error_q;
    assign bus.mem_req_valid_o   = mem_req_valid_q;
    assign bus.mem_addr_o        = mem_addr_q;
    assign bus.mem_wr_o          = mem_wr_q;
    assign bus.mem_wdata_o       = mem_wdata_q;
    assign bus.mem_be_o          = mem_be_q;
endmodule
